// File: rtl/psg_pkg.sv
// psg_pkg: shared constants, volume tables and register map helpers for the multi-channel PSG
package psg_pkg;
  localparam int ADDR_W = 5;
  localparam int SH_C = 3;
  localparam int SH_AT = 2;
  localparam int SH_AL = 1;
  localparam int SH_H = 0;
  typedef enum logic [1:0] {ATTACK, DECAY, HOLD} env_st_t;
  localparam logic [7:0] AY [16] = '{
    8'h00, 8'h03, 8'h04, 8'h06, 8'h0a, 8'h0f, 8'h15, 8'h22,
    8'h28, 8'h41, 8'h5b, 8'h72, 8'h90, 8'hb5, 8'hd7, 8'hff};
  localparam logic [7:0] YM [32] = '{
    8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
    8'h06, 8'h07, 8'h09, 8'h0a, 8'h0c, 8'h0e, 8'h11, 8'h13,
    8'h17, 8'h1b, 8'h20, 8'h25, 8'h2c, 8'h35, 8'h3e, 8'h47,
    8'h54, 8'h66, 8'h77, 8'h88, 8'ha1, 8'hc0, 8'he0, 8'hff};
  function automatic int reg_noise(int n); return 2 * n; endfunction
  function automatic int reg_tdis(int n); return 2 * n + 1; endfunction
  function automatic int reg_ndis(int n); return 2 * n + 2; endfunction
  function automatic int reg_vol(int n, int i); return 2 * n + 3 + i; endfunction
  function automatic int reg_envl(int n); return 3 * n + 3; endfunction
  function automatic int reg_envh(int n); return 3 * n + 4; endfunction
  function automatic int reg_shape(int n); return 3 * n + 5; endfunction
  function automatic int reg_panl(int n); return 3 * n + 6; endfunction
  function automatic int reg_panr(int n); return 3 * n + 7; endfunction
endpackage

// File: rtl/psg_if.sv
// psg_if: register write/read bus of the PSG
interface psg_if;
  logic WR;
  logic [psg_pkg::ADDR_W-1:0] ADDR;
  logic [7:0] DI;
  logic [7:0] DO;
  modport master (output WR, ADDR, DI, input DO);
  modport slave (input WR, ADDR, DI, output DO);
endinterface

// File: rtl/psg_envelope.sv
// psg_envelope: envelope period counter and AY shape sequencer producing a 5-bit level
module psg_envelope import psg_pkg::*; #(
  parameter int ENV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             tick8,
  input  logic             restart,
  input  logic [ENV_W-1:0] period,
  input  logic [3:0]       shape,
  output logic [4:0]       level
);
  env_st_t st, st_n;
  logic [ENV_W-1:0] cnt, last;
  logic [4:0] lvl_n;
  logic pend, rs, wrap, at_end;
  assign last = (period == '0) ? '0 : period - ENV_W'(1);
  assign wrap = cnt >= last;
  assign rs = ce && pend;
  always_ff @(posedge clk)
    if (rst) begin
      st <= HOLD;
      level <= '0;
      cnt <= '0;
      pend <= 1'b0;
    end else begin
      st <= st_n;
      level <= lvl_n;
      pend <= restart | (pend & ~ce);
      cnt <= rs ? '0 : tick8 ? (wrap ? '0 : cnt + ENV_W'(1)) : cnt;
    end
  // at the end of a ramp: alternate keeps the peak for one more step, sawtooth jumps
  always_comb begin
    st_n = st;
    lvl_n = level;
    at_end = (st == ATTACK) ? (level == 5'd31) : (level == 5'd0);
    if (rs) begin
      st_n = shape[SH_AT] ? ATTACK : DECAY;
      lvl_n = shape[SH_AT] ? 5'd0 : 5'd31;
    end else if (tick8 && wrap && st != HOLD) begin
      if (!at_end) lvl_n = (st == ATTACK) ? level + 5'd1 : level - 5'd1;
      else if (!shape[SH_C]) begin
        st_n = HOLD;
        lvl_n = 5'd0;
      end else if (shape[SH_H]) begin
        st_n = HOLD;
        lvl_n = shape[SH_AL] ? ~level : level;
      end else if (shape[SH_AL]) st_n = (st == ATTACK) ? DECAY : ATTACK;
      else lvl_n = ~level;
    end
  end
endmodule

// File: rtl/psg_multi.sv
// psg_multi: NCH-channel AY/YM-style PSG with shared noise and envelope, per-channel and panned outputs
module psg_multi import psg_pkg::*; #(
  parameter int NCH = 3,
  parameter int TONE_W = 12,
  parameter int ENV_W = 16,
  localparam int SUM_W = 8 + $clog2(NCH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             MODE,
  psg_if.slave             bus,
  output logic [NCH*8-1:0] CH_OUT,
  output logic [SUM_W-1:0] OUT_L,
  output logic [SUM_W-1:0] OUT_R
);
  localparam logic [ADDR_W-1:0] A_NOISE = ADDR_W'(reg_noise(NCH));
  localparam logic [ADDR_W-1:0] A_TDIS = ADDR_W'(reg_tdis(NCH));
  localparam logic [ADDR_W-1:0] A_NDIS = ADDR_W'(reg_ndis(NCH));
  localparam logic [ADDR_W-1:0] A_ENVL = ADDR_W'(reg_envl(NCH));
  localparam logic [ADDR_W-1:0] A_ENVH = ADDR_W'(reg_envh(NCH));
  localparam logic [ADDR_W-1:0] A_SHAPE = ADDR_W'(reg_shape(NCH));
  localparam logic [ADDR_W-1:0] A_PANL = ADDR_W'(reg_panl(NCH));
  localparam logic [ADDR_W-1:0] A_PANR = ADDR_W'(reg_panr(NCH));
  localparam logic [7:0] THI_M = 8'((1 << (TONE_W - 8)) - 1);
  localparam logic [7:0] EHI_M = 8'((1 << (ENV_W - 8)) - 1);
  logic [7:0] tlo [NCH];
  logic [7:0] thi [NCH];
  logic [4:0] vol [NCH];
  logic [TONE_W-1:0] tcnt [NCH];
  logic [TONE_W-1:0] tper [NCH];
  logic [TONE_W-1:0] tlast [NCH];
  logic [4:0] lvl [NCH];
  logic [7:0] elo, ehi;
  logic [4:0] nper, ncnt, nlast, env;
  logic [3:0] shape, pre;
  logic [NCH-1:0] tdis, ndis, panl, panr, tone;
  logic [16:0] lfsr;
  logic [SUM_W-1:0] sum_l, sum_r;
  logic tick8, tick16;
  assign tick8 = CE && pre[2:0] == 3'd7;
  assign tick16 = CE && pre == 4'd15;
  assign nlast = (nper == '0) ? '0 : nper - 5'd1;
  always_ff @(posedge CLK)
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        tlo[i] <= '0;
        thi[i] <= '0;
        vol[i] <= '0;
      end
      nper <= '0;
      tdis <= '1;
      ndis <= '1;
      panl <= '1;
      panr <= '1;
      elo <= '0;
      ehi <= '0;
      shape <= '0;
    end else if (bus.WR) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ADDR == ADDR_W'(2 * i)) tlo[i] <= bus.DI;
        if (bus.ADDR == ADDR_W'(2 * i + 1)) thi[i] <= bus.DI & THI_M;
        if (bus.ADDR == ADDR_W'(reg_vol(NCH, i))) vol[i] <= bus.DI[4:0];
      end
      if (bus.ADDR == A_NOISE) nper <= bus.DI[4:0];
      if (bus.ADDR == A_TDIS) tdis <= bus.DI[NCH-1:0];
      if (bus.ADDR == A_NDIS) ndis <= bus.DI[NCH-1:0];
      if (bus.ADDR == A_ENVL) elo <= bus.DI;
      if (bus.ADDR == A_ENVH) ehi <= bus.DI & EHI_M;
      if (bus.ADDR == A_SHAPE) shape <= bus.DI[3:0];
      if (bus.ADDR == A_PANL) panl <= bus.DI[NCH-1:0];
      if (bus.ADDR == A_PANR) panr <= bus.DI[NCH-1:0];
    end
  always_ff @(posedge CLK)
    if (RESET) begin
      pre <= '0;
      ncnt <= '0;
      lfsr <= 17'd1;
      tone <= '0;
      for (int i = 0; i < NCH; i++) tcnt[i] <= '0;
    end else if (CE) begin
      pre <= pre + 4'd1;
      for (int i = 0; i < NCH; i++)
        if (tick8) begin
          tcnt[i] <= (tcnt[i] >= tlast[i]) ? '0 : tcnt[i] + TONE_W'(1);
          if (tcnt[i] >= tlast[i]) tone[i] <= ~tone[i];
        end
      if (tick16) begin
        ncnt <= (ncnt >= nlast) ? '0 : ncnt + 5'd1;
        if (ncnt >= nlast) lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end
    end
  psg_envelope #(.ENV_W(ENV_W)) u_env (
    .clk(CLK), .rst(RESET), .ce(CE), .tick8(tick8),
    .restart(bus.WR && bus.ADDR == A_SHAPE),
    .period(ENV_W'({ehi, elo})), .shape(shape), .level(env)
  );
  always_comb
    for (int i = 0; i < NCH; i++) begin
      tper[i] = TONE_W'({thi[i], tlo[i]});
      tlast[i] = (tper[i] == '0) ? '0 : tper[i] - TONE_W'(1);
      lvl[i] = ((tdis[i] | tone[i]) & (ndis[i] | lfsr[0])) ?
               (vol[i][4] ? env : {vol[i][3:0], vol[i][3]}) : 5'd0;
    end
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < NCH; i++) begin
      sum_l = sum_l + (panl[i] ? SUM_W'(CH_OUT[8*i+:8]) : SUM_W'(0));
      sum_r = sum_r + (panr[i] ? SUM_W'(CH_OUT[8*i+:8]) : SUM_W'(0));
    end
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      CH_OUT <= '0;
      OUT_L <= '0;
      OUT_R <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) CH_OUT[8*i+:8] <= MODE ? AY[lvl[i][4:1]] : YM[lvl[i]];
      OUT_L <= sum_l;
      OUT_R <= sum_r;
    end
  always_comb begin
    bus.DO = 8'hFF;
    for (int i = 0; i < NCH; i++) begin
      if (bus.ADDR == ADDR_W'(2 * i)) bus.DO = tlo[i];
      if (bus.ADDR == ADDR_W'(2 * i + 1)) bus.DO = thi[i];
      if (bus.ADDR == ADDR_W'(reg_vol(NCH, i))) bus.DO = {3'b0, vol[i]};
    end
    if (bus.ADDR == A_NOISE) bus.DO = {3'b0, nper};
    if (bus.ADDR == A_TDIS) bus.DO = 8'(tdis);
    if (bus.ADDR == A_NDIS) bus.DO = 8'(ndis);
    if (bus.ADDR == A_ENVL) bus.DO = elo;
    if (bus.ADDR == A_ENVH) bus.DO = ehi;
    if (bus.ADDR == A_SHAPE) bus.DO = {4'b0, shape};
    if (bus.ADDR == A_PANL) bus.DO = 8'(panl);
    if (bus.ADDR == A_PANR) bus.DO = 8'(panr);
  end
endmodule

// File: tb/tb_psg_multi.sv
// tb_psg_multi: randomized and directed checks of psg_multi against an arithmetic reference model
module tb_psg_multi;
  logic CLK = 1'b0, RESET = 1'b1, CE = 1'b0, MODE = 1'b0;
  logic [23:0] ch3;
  logic [9:0] l3, r3;
  logic [63:0] ch8;
  logic [11:0] l8, r8;
  int tests = 0, fails = 0;
  int cnt = 0, cb1 = 0, cb2 = 0;
  int kind = 0, np = 1;
  int tp [3];
  logic [7:0] hv = 8'hFF;
  logic [2:0] panr = 3'd0;
  logic [16:0] lfsr_seq [64];
  psg_if b3 ();
  psg_if b8 ();
  psg_multi #(.NCH(3)) d3 (.CLK(CLK), .RESET(RESET), .CE(CE), .MODE(MODE), .bus(b3),
                           .CH_OUT(ch3), .OUT_L(l3), .OUT_R(r3));
  psg_multi #(.NCH(8)) d8 (.CLK(CLK), .RESET(RESET), .CE(CE), .MODE(MODE), .bus(b8),
                           .CH_OUT(ch8), .OUT_L(l8), .OUT_R(r8));
  always #5 CLK = ~CLK;
  // expected channel byte given the number of CE cycles completed
  function automatic logic [7:0] exp_ch(int i, int c);
    int t8 = c / 8;
    int s = t8 % 64;
    case (kind)
      0: return ((t8 / (tp[i] == 0 ? 1 : tp[i])) % 2) != 0 ? hv : 8'h00;
      1: return psg_pkg::YM[s < 32 ? s : 63 - s];
      2: return c == 0 ? 8'h00 : psg_pkg::YM[t8 <= 31 ? 31 - t8 : 0];
      default: return lfsr_seq[(c / 16) / (np == 0 ? 1 : np)][0] ? 8'hFF : 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] exp_rd3(int a, logic [7:0] d);
    if (a < 6) return (a % 2 != 0) ? (d & 8'h0F) : d;
    if (a == 6 || (a >= 9 && a <= 11)) return d & 8'h1F;
    if (a == 7 || a == 8 || a == 15 || a == 16) return d & 8'h07;
    if (a == 12 || a == 13) return d;
    if (a == 14) return d & 8'h0F;
    return 8'hFF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic step(input logic ce);
    CE = ce;
    @(posedge CLK);
    #1;
    cb2 = cb1;
    cb1 = cnt;
    if (ce && !RESET) cnt++;
  endtask
  task automatic wr(input int dev, input int a, input int d, input logic ce);
    if (dev == 3) begin
      b3.WR = 1'b1; b3.ADDR = 5'(a); b3.DI = 8'(d);
    end else begin
      b8.WR = 1'b1; b8.ADDR = 5'(a); b8.DI = 8'(d);
    end
    step(ce);
    b3.WR = 1'b0;
    b8.WR = 1'b0;
  endtask
  task automatic rd(input int dev, input int a, input logic [7:0] e, input string tag);
    if (dev == 3) begin
      b3.ADDR = 5'(a); #1 chk(tag, 32'(b3.DO), 32'(e));
    end else begin
      b8.ADDR = 5'(a); #1 chk(tag, 32'(b8.DO), 32'(e));
    end
  endtask
  task automatic reset_dut();
    RESET = 1'b1;
    step(0);
    step(0);
    RESET = 1'b0;
    cnt = 0; cb1 = 0; cb2 = 0;
  endtask
  task automatic run(input int ncyc);
    int sl, sr;
    for (int k = 0; k < ncyc; k++) begin
      step($urandom_range(0, 3) != 0);
      chk("ch0", 32'(ch3[7:0]), 32'(exp_ch(0, cb1)));
      if (kind == 0) begin
        sl = 0; sr = 0;
        for (int i = 0; i < 3; i++) begin
          sl += exp_ch(i, cb2);
          if (panr[i]) sr += exp_ch(i, cb2);
        end
        chk("ch1", 32'(ch3[15:8]), 32'(exp_ch(1, cb1)));
        chk("ch2", 32'(ch3[23:16]), 32'(exp_ch(2, cb1)));
        chk("out_l", 32'(l3), 32'(sl));
        chk("out_r", 32'(r3), 32'(sr));
      end
    end
  endtask
  task automatic tone_setup(input int v);
    wr(3, 7, 0, 0);
    for (int i = 0; i < 3; i++) begin
      wr(3, 2 * i, tp[i], 0);
      wr(3, 9 + i, v, 0);
    end
    panr = 3'($urandom_range(0, 7));
    wr(3, 16, panr, 0);
  endtask
  initial begin
    int a, d;
    b3.WR = 1'b0; b3.ADDR = '0; b3.DI = '0;
    b8.WR = 1'b0; b8.ADDR = '0; b8.DI = '0;
    lfsr_seq[0] = 17'd1;
    for (int k = 1; k < 64; k++) lfsr_seq[k] = {lfsr_seq[k-1][0] ^ lfsr_seq[k-1][3], lfsr_seq[k-1][16:1]};
    reset_dut();
    chk("rst_ch3", 32'(ch3), 32'd0);
    chk("rst_l3", 32'(l3), 32'd0);
    chk("rst_r3", 32'(r3), 32'd0);
    chk("rst_ch8_lo", ch8[31:0], 32'd0);
    rd(3, 7, 8'h07, "rst_tdis3");
    rd(3, 15, 8'h07, "rst_panl3");
    rd(3, 6, 8'h00, "rst_noise3");
    rd(3, 31, 8'hFF, "unmapped31");
    rd(8, 17, 8'hFF, "rst_tdis8");
    for (int k = 0; k < 24; k++) begin
      a = $urandom_range(0, 31);
      d = $urandom_range(0, 255);
      wr(3, a, d, 0);
      rd(3, a, exp_rd3(a, 8'(d)), "readback");
    end
    reset_dut();
    MODE = 1'b0; kind = 0; hv = 8'hFF;
    tp[0] = 1; tp[1] = 0; tp[2] = $urandom_range(2, 5);
    tone_setup(15);
    run(160);
    reset_dut();
    MODE = 1'b1; hv = 8'h28;
    for (int i = 0; i < 3; i++) tp[i] = $urandom_range(0, 4);
    tone_setup(8);
    run(160);
    reset_dut();
    MODE = 1'b0; kind = 1;
    wr(3, 12, 1, 0);
    wr(3, 9, 8'h10, 0);
    wr(3, 14, 8'h0E, 0);
    run(800);
    wr(3, 14, 8'h00, 1);
    step(1);
    step(0);
    chk("restart_dn", 32'(ch3[7:0]), 32'hFF);
    wr(3, 14, 8'h0D, 0);
    step(0);
    step(0);
    chk("restart_wait_ce", 32'(ch3[7:0]), 32'hFF);
    step(1);
    step(0);
    chk("restart_up", 32'(ch3[7:0]), 32'h00);
    reset_dut();
    kind = 2;
    wr(3, 12, 1, 0);
    wr(3, 9, 8'h10, 0);
    wr(3, 14, 8'h09, 0);
    run(420);
    reset_dut();
    kind = 3;
    np = $urandom_range(0, 3);
    wr(3, 6, np, 0);
    wr(3, 8, 6, 0);
    wr(3, 9, 15, 0);
    run(300);
    reset_dut();
    for (int i = 0; i < 8; i++) wr(8, 19 + i, 15, 0);
    wr(8, 31, 0, 0);
    step(0);
    step(0);
    for (int i = 0; i < 8; i++) chk("d8_ch", 32'(ch8[8*i+:8]), 32'hFF);
    chk("d8_out_l", 32'(l8), 32'd2040);
    chk("d8_out_r", 32'(r8), 32'd0);
    reset_dut();
    wr(3, 7, 0, 0);
    wr(3, 0, 1, 0);
    wr(3, 9, 15, 0);
    for (int k = 0; k < 10; k++) step(1);
    chk("pre_rst_ch0", 32'(ch3[7:0]), 32'hFF);
    RESET = 1'b1;
    b3.WR = 1'b1; b3.ADDR = 5'd0; b3.DI = 8'h55;
    step(1);
    RESET = 1'b0;
    b3.WR = 1'b0;
    chk("mid_rst_ch3", 32'(ch3), 32'd0);
    chk("mid_rst_l3", 32'(l3), 32'd0);
    chk("mid_rst_r3", 32'(r3), 32'd0);
    rd(3, 0, 8'h00, "rst_over_wr");
    rd(8, 17, 8'hFF, "tdis8_ff");
    rd(3, 31, 8'hFF, "addr31_ff");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
